// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared types for the SNN inference-run sequencer:
//                FSM state encoding and winner-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    // Run sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } snn_state_e;

    // Width of an index into n outputs; never less than one bit.
    function automatic int WINNER_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : snn_argmax
//  Description : Combinational argmax over packed per-output spike counts.
//                Ties resolve to the lowest index; all-zero yields index 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_argmax
    import snn_pkg::*;
#(
    parameter int NUM_OUTPUTS = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] counts,
    output logic [WINNER_W(NUM_OUTPUTS)-1:0]   winner
);

    localparam int WW = WINNER_W(NUM_OUTPUTS);

    logic [COUNT_WIDTH-1:0] best;

    // Linear scan; strict greater-than keeps the earliest maximum.
    always_comb begin
        best   = counts[0 +: COUNT_WIDTH];
        winner = '0;
        for (int j = 1; j < NUM_OUTPUTS; j++) begin
            if (counts[j*COUNT_WIDTH +: COUNT_WIDTH] > best) begin
                best   = counts[j*COUNT_WIDTH +: COUNT_WIDTH];
                winner = WW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snn_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snn_run_ctrl
//  Description : Inference-run sequencer for the SNN core. Latches channel
//                config, clears the network, drives rate-coded input spikes
//                for num_timesteps, drains network latency, counts output
//                spikes and reports the winning output index.
//                Optional: define SNN_RUN_CTRL_EARLY_STOP_EN to add the
//                stop_count input that ends RUN once any count reaches it.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_run_ctrl
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS     = 4,
    parameter int NUM_OUTPUTS    = 4,
    parameter int PERIOD_WIDTH   = 8,
    parameter int TIMESTEP_WIDTH = 16,
    parameter int COUNT_WIDTH    = 16,
    parameter int NET_LATENCY    = 2
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESETN,
    input  logic                                start,
    input  logic                                abort,
    input  logic [TIMESTEP_WIDTH-1:0]           num_timesteps,
    input  logic [NUM_INPUTS-1:0]               spike_en,
    input  logic [NUM_INPUTS*PERIOD_WIDTH-1:0]  spike_period,
`ifdef SNN_RUN_CTRL_EARLY_STOP_EN
    input  logic [COUNT_WIDTH-1:0]              stop_count,
`endif
    output logic                                net_rst,
    output logic [NUM_INPUTS-1:0]               spike_in_net,
    input  logic [NUM_OUTPUTS-1:0]              spike_out_net,
    output logic                                busy,
    output logic                                done,
    output logic [TIMESTEP_WIDTH-1:0]           timestep,
    output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0]  spike_count,
    output logic [WINNER_W(NUM_OUTPUTS)-1:0]    winner,
    output logic                                winner_valid
);

    localparam int PW      = PERIOD_WIDTH;
    localparam int CW      = COUNT_WIDTH;
    localparam int WW      = WINNER_W(NUM_OUTPUTS);
    localparam int DRAIN_W = (NET_LATENCY > 1) ? $clog2(NET_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((NET_LATENCY > 0) ? NET_LATENCY - 1 : 0);
    // With zero network latency the drain phase is skipped entirely.
    localparam snn_state_e END_STATE = (NET_LATENCY == 0) ? ST_DONE : ST_DRAIN;

    snn_state_e                   state_q,        state_d;
    logic [TIMESTEP_WIDTH-1:0]    num_ts_q,       num_ts_d;
    logic [NUM_INPUTS-1:0]        en_q,           en_d;
    logic [NUM_INPUTS*PW-1:0]     period_q,       period_d;
    logic [NUM_INPUTS*PW-1:0]     phase_q,        phase_d;
    logic [TIMESTEP_WIDTH-1:0]    timestep_q,     timestep_d;
    logic [DRAIN_W-1:0]           drain_q,        drain_d;
    logic [NUM_OUTPUTS*CW-1:0]    count_q,        count_d;
    logic [NUM_INPUTS-1:0]        spike_q,        spike_d;
    logic                         net_rst_q,      net_rst_d;
    logic                         busy_q,         busy_d;
    logic                         done_q,         done_d;
    logic [WW-1:0]                winner_q,       winner_d;
    logic                         winner_valid_q, winner_valid_d;

    logic [WW-1:0]                argmax_idx;
    logic                         stop_hit;
    logic                         abort_run;

    assign abort_run = abort && (state_q != ST_IDLE);

    // Phase for the following timestep: wraps at period-1, parked at 0 when disabled.
    function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] ph,
                                                 input logic [PW-1:0] per);
        if ((per == '0) || (ph == per - PW'(1)))
            return '0;
        return ph + PW'(1);
    endfunction

    snn_argmax #(
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_argmax (
        .counts (count_d),
        .winner (argmax_idx)
    );

    // Output spike counters: cleared in CLEAR, saturating in RUN/DRAIN, frozen on abort.
    always_comb begin
        count_d = count_q;
        if (abort_run) begin
            count_d = count_q;
        end else if (state_q == ST_CLEAR) begin
            count_d = '0;
        end else if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                if (spike_out_net[j] &&
                    (count_q[j*CW +: CW] != {CW{1'b1}})) begin
                    count_d[j*CW +: CW] = count_q[j*CW +: CW] + CW'(1);
                end
            end
        end
    end

`ifdef SNN_RUN_CTRL_EARLY_STOP_EN
    // Early stop fires when any updated count equals a nonzero threshold.
    always_comb begin
        stop_hit = 1'b0;
        if (stop_count != '0) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                if (count_d[j*CW +: CW] == stop_count)
                    stop_hit = 1'b1;
            end
        end
    end
`else
    assign stop_hit = 1'b0;
`endif

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        num_ts_d       = num_ts_q;
        en_d           = en_q;
        period_d       = period_q;
        phase_d        = phase_q;
        timestep_d     = timestep_q;
        drain_d        = drain_q;
        spike_d        = '0;
        done_d         = 1'b0;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    winner_valid_d = 1'b0;
                end else if (start) begin
                    state_d        = ST_CLEAR;
                    winner_valid_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                num_ts_d   = num_timesteps;
                en_d       = spike_en;
                period_d   = spike_period;
                timestep_d = '0;
                drain_d    = '0;
                // Spikes for timestep 0 come from phase 0; phase_q then holds timestep 1's phase.
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    spike_d[i] = spike_en[i] &&
                                 (spike_period[i*PW +: PW] != '0);
                    phase_d[i*PW +: PW] = next_phase('0, spike_period[i*PW +: PW]);
                end
                if (num_timesteps == '0) begin
                    state_d = END_STATE;
                    spike_d = '0;
                    phase_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if ((timestep_q == num_ts_q - TIMESTEP_WIDTH'(1)) || stop_hit) begin
                    state_d = END_STATE;
                end else begin
                    timestep_d = timestep_q + TIMESTEP_WIDTH'(1);
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        spike_d[i] = en_q[i] &&
                                     (period_q[i*PW +: PW] != '0) &&
                                     (phase_q[i*PW +: PW] == '0);
                        phase_d[i*PW +: PW] = next_phase(phase_q[i*PW +: PW],
                                                         period_q[i*PW +: PW]);
                    end
                end
            end

            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST)
                    state_d = ST_DONE;
                else
                    drain_d = drain_q + DRAIN_W'(1);
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // DONE is only ever entered, never held, so this marks the single done cycle.
        if (state_d == ST_DONE) begin
            done_d         = 1'b1;
            winner_valid_d = 1'b1;
            winner_d       = argmax_idx;
        end

        if (abort_run) begin
            state_d        = ST_IDLE;
            spike_d        = '0;
            done_d         = 1'b0;
            winner_d       = winner_q;
            winner_valid_d = 1'b0;
        end

        net_rst_d = (state_d == ST_CLEAR);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q        <= ST_IDLE;
            num_ts_q       <= '0;
            en_q           <= '0;
            period_q       <= '0;
            phase_q        <= '0;
            timestep_q     <= '0;
            drain_q        <= '0;
            count_q        <= '0;
            spike_q        <= '0;
            net_rst_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_ts_q       <= num_ts_d;
            en_q           <= en_d;
            period_q       <= period_d;
            phase_q        <= phase_d;
            timestep_q     <= timestep_d;
            drain_q        <= drain_d;
            count_q        <= count_d;
            spike_q        <= spike_d;
            net_rst_q      <= net_rst_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
        end
    end

    assign net_rst      = net_rst_q;
    assign spike_in_net = spike_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timestep     = timestep_q;
    assign spike_count  = count_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_snn_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snn_run_ctrl
//  Description : Self-checking bench for snn_run_ctrl with a scoreboard of
//                expected run results (latency, counts, winner).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_run_ctrl;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int PW = 8;
    localparam int TW = 16;
    localparam int CW = 16;
    localparam int NL = 2;

    typedef struct {
        int          lat;
        logic [63:0] cnt;
        int          win;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, start2, abort;
    logic [TW-1:0]     num_ts;
    logic [NI-1:0]     en;
    logic [NI*PW-1:0]  per;
    logic              tie;
    logic              frc_on;
    logic [NO-1:0]     frc;
    logic [NO-1:0]     spike_out;
    logic              net_rst, busy, done, winner_valid;
    logic [NI-1:0]     spk_in;
    logic [TW-1:0]     timestep;
    logic [NO*CW-1:0]  count;
    logic [1:0]        winner;
`ifdef SNN_RUN_CTRL_EARLY_STOP_EN
    logic [CW-1:0]     stop_cnt;
`endif

    logic              net_rst2, busy2, done2, winner_valid2;
    logic [NI-1:0]     spk_in2;
    logic [TW-1:0]     timestep2;
    logic [NO*3-1:0]   count2;
    logic [1:0]        winner2;

    always #5 clk = ~clk;

    assign spike_out = tie ? spk_in : (frc_on ? frc : '0);

    snn_run_ctrl #(
        .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .PERIOD_WIDTH(PW),
        .TIMESTEP_WIDTH(TW), .COUNT_WIDTH(CW), .NET_LATENCY(NL)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
        .num_timesteps(num_ts), .spike_en(en), .spike_period(per),
`ifdef SNN_RUN_CTRL_EARLY_STOP_EN
        .stop_count(stop_cnt),
`endif
        .net_rst(net_rst), .spike_in_net(spk_in), .spike_out_net(spike_out),
        .busy(busy), .done(done), .timestep(timestep), .spike_count(count),
        .winner(winner), .winner_valid(winner_valid)
    );

    snn_run_ctrl #(
        .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .PERIOD_WIDTH(PW),
        .TIMESTEP_WIDTH(TW), .COUNT_WIDTH(3), .NET_LATENCY(NL)
    ) dut_sat (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start2), .abort(1'b0),
        .num_timesteps(num_ts), .spike_en(en), .spike_period(per),
`ifdef SNN_RUN_CTRL_EARLY_STOP_EN
        .stop_count(3'd0),
`endif
        .net_rst(net_rst2), .spike_in_net(spk_in2), .spike_out_net(spk_in2),
        .busy(busy2), .done(done2), .timestep(timestep2), .spike_count(count2),
        .winner(winner2), .winner_valid(winner_valid2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference spike rule: channel fires when enabled, period nonzero, t a multiple of period.
    function automatic logic [3:0] model_spk(input int t, input logic [3:0] e, input logic [31:0] p);
        logic [3:0] r;
        int pv;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            pv = int'(p[i*8 +: 8]);
            r[i] = e[i] && (pv != 0) && ((t % pv) == 0);
        end
        return r;
    endfunction

    task automatic do_run(input string name, input int n, input logic [3:0] e,
                          input logic [31:0] p, input bit tie_m, input logic [3:0] f,
                          input bit fwin, input int stop, input bit chg);
        int         eff;
        int         cnt[4];
        int         best;
        logic [3:0] tab[64];
        logic [3:0] s;
        logic [3:0] exp_s;
        exp_t       x;
        exp_t       y;
        bit         got;
        bit         hit;

        eff = n;
        for (int j = 0; j < 4; j++) cnt[j] = 0;
        for (int t = 0; t < n; t++) begin
            s = model_spk(t, e, p);
            tab[t] = s;
            hit = 1'b0;
            for (int j = 0; j < 4; j++) begin
                cnt[j] += tie_m ? int'(s[j]) : int'(f[j]);
                if (stop != 0 && cnt[j] == stop) hit = 1'b1;
            end
            if (hit) begin
                eff = t + 1;
                break;
            end
        end
        if (fwin && !tie_m)
            for (int j = 0; j < 4; j++) cnt[j] += int'(f[j]) * NL;
        x.lat = 2 + eff + NL;
        x.win = 0;
        best  = cnt[0];
        for (int j = 1; j < 4; j++)
            if (cnt[j] > best) begin best = cnt[j]; x.win = j; end
        for (int j = 0; j < 4; j++) x.cnt[j*16 +: 16] = 16'(cnt[j]);
        sb.push_back(x);

        @(negedge clk);
        num_ts = TW'(n); en = e; per = p; tie = tie_m; frc = f; frc_on = 1'b0;
`ifdef SNN_RUN_CTRL_EARLY_STOP_EN
        stop_cnt = CW'(stop);
`endif
        start = 1'b1;
        got = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            frc_on = fwin ? (k >= 1 && k <= eff + 2 + NL) : (k >= 2 && k < 2 + eff);
            if (k == 1) begin
                start = 1'b0;
                check({name, "_net_rst"}, net_rst, 1);
                check({name, "_busy"}, busy, 1);
            end else begin
                check({name, "_net_rst_low"}, net_rst, 0);
            end
            exp_s = (k >= 2 && k < 2 + eff) ? tab[k-2] : 4'b0;
            check({name, "_spike_in"}, spk_in, exp_s);
            if (k >= 2 && k < 2 + eff) check({name, "_timestep"}, timestep, k - 2);
            if (chg && k == 4) begin start = 1'b1; per = 32'h01010101; en = 4'hF; end
            if (chg && k == 5) start = 1'b0;
            if (done) begin
                y = sb.pop_front();
                check({name, "_latency"}, k, y.lat);
                check({name, "_counts"}, count, y.cnt);
                check({name, "_winner"}, winner, y.win);
                check({name, "_winner_valid"}, winner_valid, 1);
                got = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, got, 1);
        @(negedge clk);
        frc_on = 1'b0;
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_done"}, done, 0);
        check({name, "_hold_valid"}, winner_valid, 1);
        check({name, "_hold_winner"}, winner, x.win);
        check({name, "_hold_counts"}, count, x.cnt);
        tie = 1'b0;
    endtask

    initial begin
        bit          saw;
        bit          got;
        logic [63:0] exp_c;

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0;
        num_ts = '0; en = '0; per = '0; tie = 1'b0; frc = '0; frc_on = 1'b0;
`ifdef SNN_RUN_CTRL_EARLY_STOP_EN
        stop_cnt = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_net_rst", net_rst, 0);
        check("rst_spike_in", spk_in, 0);
        check("rst_count", count, 0);
        check("rst_winner", winner, 0);
        check("rst_valid", winner_valid, 0);
        check("rst_timestep", timestep, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run("basic",   6, 4'b0011, 32'h00000301, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        do_run("zero_ts", 0, 4'b0011, 32'h00000301, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        do_run("force3",  8, 4'b0000, 32'h00000000, 1'b0, 4'b1000, 1'b0, 0, 1'b0);
        do_run("tie55",   5, 4'b0011, 32'h00000101, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        do_run("win2",    4, 4'b0110, 32'h00010200, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        do_run("fdrain",  3, 4'b0000, 32'h00000000, 1'b0, 4'b0110, 1'b1, 0, 1'b0);
        do_run("midrun",  9, 4'b0011, 32'h00000301, 1'b1, 4'b0000, 1'b0, 0, 1'b1);
`ifdef SNN_RUN_CTRL_EARLY_STOP_EN
        do_run("estop",  10, 4'b0001, 32'h00000001, 1'b1, 4'b0000, 1'b0, 3, 1'b0);
        stop_cnt = '0;
`endif

        // Abort at RUN timestep 2: timesteps 0 and 1 counted, nothing after.
        @(negedge clk);
        num_ts = 16'd8; en = 4'b0011; per = 32'h00000301; tie = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_at_ts", timestep, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_c = 64'h0000_0000_0001_0002;
        check("abort_busy", busy, 0);
        check("abort_spike", spk_in, 0);
        check("abort_valid", winner_valid, 0);
        check("abort_counts", count, exp_c);
        saw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            saw |= done | busy;
        end
        check("abort_no_done", saw, 0);
        check("abort_counts_frozen", count, exp_c);
        tie = 1'b0;

        // Abort and start together in IDLE: run must not start, valid cleared.
        do_run("pre_as",  2, 4'b0001, 32'h00000001, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("as_busy", busy, 0);
        check("as_net_rst", net_rst, 0);
        check("as_valid", winner_valid, 0);
        @(negedge clk);
        check("as_busy2", busy, 0);

        // Saturation on the 3-bit-counter instance: 12 spikes clamp at 7.
        num_ts = 16'd12; en = 4'b0001; per = 32'h00000001; start2 = 1'b1;
        got = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) start2 = 1'b0;
            if (done2) begin
                check("sat_latency", k, 12 + 2 + NL);
                check("sat_count0", count2[2:0], 7);
                check("sat_count_rest", count2[11:3], 0);
                check("sat_winner", winner2, 0);
                got = 1'b1;
                break;
            end
        end
        check("sat_done_seen", got, 1);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        num_ts = 16'd20; en = 4'b0011; per = 32'h00000301; tie = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_count", count, 0);
        check("mrst_spike", spk_in, 0);
        check("mrst_timestep", timestep, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tie = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
